snake_game_fsm: RTL and testbench

SNAKE_GAME_FSM -- requirements
Module: snake_game_fsm

---
 rtl/snake_pkg.sv | 28 ++
 rtl/lfsr8.sv | 21 ++
 rtl/snake_game_fsm.sv | 166 ++++++++++++++++
 tb/tb_snake_game_fsm.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings and constants for the snake game controller.
package snake_pkg;

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_PLACE = 5'b00010,
        ST_PLAY  = 5'b00100,
        ST_WIN   = 5'b01000,
        ST_LOSE  = 5'b10000
    } state_t;

    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_D = 2'd1,
        DIR_L = 2'd2,
        DIR_R = 2'd3
    } dir_t;

    localparam int         GRID_DIM  = 16;
    localparam int         MAX_SEG   = 16;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Opposite directions differ only in bit 0 (U/D and L/R pairs).
    function automatic logic is_reverse(input dir_t cur, input dir_t req);
        return (cur ^ req) == 2'b01;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit maximal-length Fibonacci LFSR (x^8+x^6+x^5+x^4+1).
module lfsr8
    import snake_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    output logic [7:0] o_value
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign o_value = r_lfsr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_lfsr <= LFSR_SEED;
        else          r_lfsr <= {r_lfsr[6:0], w_fb};
    end

endmodule

// File: rtl/snake_game_fsm.sv
// Snake game controller: one-hot game FSM, segment shift register, food placement.
// Optional macro WRAP_WALLS_EN makes the 16x16 grid wrap instead of killing the snake.
//
// state    | meaning
// ST_INIT  | snake loaded, waiting for Start
// ST_PLACE | searching LFSR for a food cell not on the snake
// ST_PLAY  | moving on Tick, direction buttons accepted
// ST_WIN   | length reached WIN_LEN, waiting for Start
// ST_LOSE  | wall or self hit, snake frozen, waiting for Start
module snake_game_fsm
    import snake_pkg::*;
#(
    parameter int         WIN_LEN   = 15,
    parameter int         INIT_LEN  = 3,
    parameter logic [7:0] INIT_HEAD = 8'h88
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Tick,
    input  logic         Start,
    input  logic         BtnU,
    input  logic         BtnD,
    input  logic         BtnL,
    input  logic         BtnR,
    output logic         Qi,
    output logic         Qc,
    output logic         Qp,
    output logic         Qw,
    output logic         Ql,
    output logic [7:0]   Food,
    output logic [3:0]   Length,
    output logic [127:0] Locations_Flat
);

`ifdef WRAP_WALLS_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    state_t     r_state, w_state_nxt;
    dir_t       r_dir, w_dir_nxt, w_req;
    logic [3:0] r_len, w_len_nxt, w_len_new;
    logic [7:0] r_food, w_food_nxt;
    logic [7:0] r_seg [MAX_SEG];
    logic [7:0] w_seg_nxt [MAX_SEG];
    logic [7:0] w_lfsr, w_head;
    logic [3:0] w_row, w_col;
    logic [4:0] w_hit_lim;
    logic       w_edge, w_off_grid, w_eat, w_hit, w_on_snake, w_btn_any;

    function automatic logic [7:0] init_cell(input int k);
        if (k < INIT_LEN) return INIT_HEAD - 8'(k);
        return 8'h00;
    endfunction

    lfsr8 u_lfsr (.Clk(Clk), .Reset_n(Reset_n), .o_value(w_lfsr));

    always_comb begin
        w_row  = r_seg[0][7:4];
        w_col  = r_seg[0][3:0];
        w_edge = 1'b0;
        case (r_dir)
            DIR_U: begin w_edge = (w_row == 4'd0);  w_row = w_row - 4'd1; end
            DIR_D: begin w_edge = (w_row == 4'd15); w_row = w_row + 4'd1; end
            DIR_L: begin w_edge = (w_col == 4'd0);  w_col = w_col - 4'd1; end
            default: begin w_edge = (w_col == 4'd15); w_col = w_col + 4'd1; end
        endcase
        w_head     = {w_row, w_col};
        w_off_grid = w_edge && !WRAP_EN;
        w_eat      = (w_head == r_food);
    end

    // The tail cell vacates on a plain move, so it is excluded from the hit test.
    always_comb begin
        w_hit_lim  = w_eat ? {1'b0, r_len} : ({1'b0, r_len} - 5'd1);
        w_hit      = 1'b0;
        w_on_snake = 1'b0;
        for (int k = 0; k < MAX_SEG; k++) begin
            if (k < int'(w_hit_lim) && r_seg[k] == w_head) w_hit = 1'b1;
            if (k < int'(r_len) && r_seg[k] == w_lfsr) w_on_snake = 1'b1;
        end
    end

    always_comb begin
        w_btn_any = BtnU | BtnD | BtnL | BtnR;
        if (BtnU)      w_req = DIR_U;
        else if (BtnD) w_req = DIR_D;
        else if (BtnL) w_req = DIR_L;
        else           w_req = DIR_R;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_len_nxt   = r_len;
        w_food_nxt  = r_food;
        w_len_new   = w_eat ? (r_len + 4'd1) : r_len;
        for (int k = 0; k < MAX_SEG; k++) w_seg_nxt[k] = r_seg[k];
        case (r_state)
            ST_INIT: if (Start) w_state_nxt = ST_PLACE;
            ST_PLACE: begin
                if (!w_on_snake) begin
                    w_food_nxt  = w_lfsr;
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_btn_any && !is_reverse(r_dir, w_req)) w_dir_nxt = w_req;
                if (Tick) begin
                    if (w_off_grid || w_hit) begin
                        w_state_nxt = ST_LOSE;
                    end else begin
                        w_len_nxt    = w_len_new;
                        w_seg_nxt[0] = w_head;
                        for (int k = 1; k < MAX_SEG; k++)
                            w_seg_nxt[k] = (k < int'(w_len_new)) ? r_seg[k-1] : 8'h00;
                        if (w_eat)
                            w_state_nxt = (int'(w_len_new) == WIN_LEN) ? ST_WIN : ST_PLACE;
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (Start) begin
                    w_state_nxt = ST_INIT;
                    w_dir_nxt   = DIR_R;
                    w_len_nxt   = 4'(INIT_LEN);
                    for (int k = 0; k < MAX_SEG; k++) w_seg_nxt[k] = init_cell(k);
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= ST_INIT;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dir  <= DIR_R;
            r_len  <= 4'(INIT_LEN);
            r_food <= 8'h00;
            for (int k = 0; k < MAX_SEG; k++) r_seg[k] <= init_cell(k);
        end else begin
            r_dir  <= w_dir_nxt;
            r_len  <= w_len_nxt;
            r_food <= w_food_nxt;
            for (int k = 0; k < MAX_SEG; k++) r_seg[k] <= w_seg_nxt[k];
        end
    end

    assign Qi     = r_state[0];
    assign Qc     = r_state[1];
    assign Qp     = r_state[2];
    assign Qw     = r_state[3];
    assign Ql     = r_state[4];
    assign Food   = r_food;
    assign Length = r_len;

    always_comb begin
        for (int k = 0; k < MAX_SEG; k++) Locations_Flat[127-8*k -: 8] = r_seg[k];
    end

endmodule

// File: tb/tb_snake_game_fsm.sv
// Randomized scoreboard bench for snake_game_fsm against a queue-based game model.
module tb_snake_game_fsm;

    localparam int         WIN_LEN   = 6;
    localparam int         INIT_LEN  = 3;
    localparam logic [7:0] INIT_HEAD = 8'h88;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Tick = 1'b0, Start = 1'b0;
    logic         BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
    logic         Qi, Qc, Qp, Qw, Ql;
    logic [7:0]   Food;
    logic [3:0]   Length;
    logic [127:0] Locations_Flat;

    snake_game_fsm #(.WIN_LEN(WIN_LEN), .INIT_LEN(INIT_LEN), .INIT_HEAD(INIT_HEAD)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Tick(Tick), .Start(Start),
        .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
        .Qi(Qi), .Qc(Qc), .Qp(Qp), .Qw(Qw), .Ql(Ql),
        .Food(Food), .Length(Length), .Locations_Flat(Locations_Flat)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]   q;     // {Ql,Qw,Qp,Qc,Qi}
        logic [7:0]   food;
        logic [3:0]   len;
        logic [127:0] flat;
    } snap_t;

    snap_t sb[$];
    int total = 0;
    int bad = 0;
    int n_eat = 0, n_win = 0, n_lose = 0;

    // Game model: 0 init, 1 place, 2 play, 3 win, 4 lose; dir U=0 D=1 L=2 R=3.
    int m_st, m_dir, m_food, m_lfsr;
    int m_body[$];

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | fb) & 8'hFF;
    endfunction

    task automatic model_reload();
        m_body.delete();
        for (int i = 0; i < INIT_LEN; i++) m_body.push_back((int'(INIT_HEAD) - i) & 8'hFF);
        m_dir = 3;
    endtask

    task automatic model_reset();
        m_st = 0; m_food = 0; m_lfsr = 8'hA5;
        model_reload();
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.q    = 5'(1 << m_st);
        s.food = 8'(m_food);
        s.len  = 4'(m_body.size());
        s.flat = '0;
        for (int i = 0; i < m_body.size(); i++) s.flat[127-8*i -: 8] = 8'(m_body[i]);
        return s;
    endfunction

    task automatic model_step(input bit t, input bit st, input bit u, input bit d,
                              input bit l, input bit r);
        int cur_lfsr, req, row, col, nh, lim;
        bit off, eat, hit;
        cur_lfsr = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        case (m_st)
            0: if (st) m_st = 1;
            1: begin
                hit = 0;
                foreach (m_body[i]) if (m_body[i] == cur_lfsr) hit = 1;
                if (!hit) begin m_food = cur_lfsr; m_st = 2; end
            end
            2: begin
                row = m_body[0] / 16; col = m_body[0] % 16;
                case (m_dir)
                    0: row--;
                    1: row++;
                    2: col--;
                    default: col++;
                endcase
                req = u ? 0 : d ? 1 : l ? 2 : r ? 3 : -1;
                if (req >= 0 && !((m_dir == 0 && req == 1) || (m_dir == 1 && req == 0) ||
                                  (m_dir == 2 && req == 3) || (m_dir == 3 && req == 2)))
                    m_dir = req;
                if (t) begin
                    off = (row < 0 || row > 15 || col < 0 || col > 15);
`ifdef WRAP_WALLS_EN
                    off = 0;
`endif
                    row = (row + 16) % 16; col = (col + 16) % 16;
                    nh = row * 16 + col;
                    eat = (nh == m_food);
                    lim = eat ? m_body.size() : m_body.size() - 1;
                    hit = 0;
                    for (int i = 0; i < lim; i++) if (m_body[i] == nh) hit = 1;
                    if (off || hit) begin
                        m_st = 4; n_lose++;
                    end else begin
                        m_body.push_front(nh);
                        if (!eat) void'(m_body.pop_back());
                        else begin
                            n_eat++;
                            if (m_body.size() == WIN_LEN) begin m_st = 3; n_win++; end
                            else m_st = 1;
                        end
                    end
                end
            end
            default: if (st) begin m_st = 0; model_reload(); end
        endcase
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, want);
        end
    endtask

    task automatic check_snap(input string tag, input snap_t e);
        check({tag, "_q"},    128'({Ql, Qw, Qp, Qc, Qi}), 128'(e.q));
        check({tag, "_food"}, 128'(Food), 128'(e.food));
        check({tag, "_len"},  128'(Length), 128'(e.len));
        check({tag, "_locs"}, Locations_Flat, e.flat);
    endtask

    always @(posedge Clk) begin
        #1;
        if (sb.size() > 0) check_snap("cyc", sb.pop_front());
    end

    initial begin
        bit t, st, u, d, l, r, do_rst;
        int hr, hc, fr, fc;
        repeat (3) @(negedge Clk);
        model_reset();
        #1 check_snap("por", model_snap());
        Reset_n = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge Clk);
            Reset_n = 1'b1;
            do_rst = ($urandom_range(0, 399) == 0) || (m_st == 1 && $urandom_range(0, 4) == 0);
            if (do_rst) begin
                {Tick, Start, BtnU, BtnD, BtnL, BtnR} = '0;
                Reset_n = 1'b0;
                model_reset();
                #1 check_snap("async_rst", model_snap());
                sb.push_back(model_snap());
                continue;
            end
            t  = ($urandom_range(0, 2) == 0);
            st = (m_st == 2) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 5) == 0);
            {u, d, l, r} = '0;
            if (m_st == 2 && $urandom_range(0, 1) == 0) begin
                hr = m_body[0] / 16; hc = m_body[0] % 16;
                fr = m_food / 16;    fc = m_food % 16;
                if (fr < hr) u = 1; else if (fr > hr) d = 1;
                else if (fc < hc) l = 1; else if (fc > hc) r = 1;
            end else begin
                u = ($urandom_range(0, 5) == 0); d = ($urandom_range(0, 5) == 0);
                l = ($urandom_range(0, 5) == 0); r = ($urandom_range(0, 5) == 0);
            end
            Tick = t; Start = st; BtnU = u; BtnD = d; BtnL = l; BtnR = r;
            model_step(t, st, u, d, l, r);
            sb.push_back(model_snap());
        end
        @(negedge Clk);
        {Tick, Start, BtnU, BtnD, BtnL, BtnR} = '0;
        @(posedge Clk);
        #2;
        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("events: eats=%0d wins=%0d loses=%0d", n_eat, n_win, n_lose);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
